// File: rtl/weight_bank.sv
// rtl/weight_bank.sv - signed weight store with overwrite/saturating-accumulate writes and an init sweep
// Optional: define WEIGHT_BANK_RAND_INIT_EN to seed the sweep from a 16-bit LFSR instead of zeros.
module weight_bank #(
    parameter int          DATA_W    = 10,
    parameter int          DEPTH     = 65,
    parameter int          ADDR_W    = 7,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              Clock,
    input  logic              Rst,
    input  logic              init_start,
    output logic              busy,
    input  logic              wr_en,
    input  logic              wr_mode,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              addr_err,
    output logic              sat_flag
);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W - 1){1'b0}}};

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] init_val;

    logic              run, wr_ok, rd_ok, wr_act, rd_act;
    logic [DATA_W:0]   sum;
    logic              clip;
    logic [DATA_W-1:0] acc_val;

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            ST_INIT: begin
                ptr_next = ptr + ADDR_W'(1);
                if (ptr == LAST) begin
                    state_next = ST_RUN;
                    ptr_next   = '0;
                end
            end
            ST_RUN: begin
                if (init_start) begin
                    state_next = ST_INIT;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = ST_INIT;
                ptr_next   = '0;
            end
        endcase
    end

    assign busy   = (state == ST_INIT);
    assign run    = (state == ST_RUN);
    assign wr_ok  = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_ok  = ({1'b0, rd_addr} < DEPTH_L);
    assign wr_act = run & wr_en & wr_ok;
    assign rd_act = run & rd_en;

    // One extra bit of headroom: overflow shows up as disagreement of the top two bits.
    always_comb begin
        sum     = {mem[wr_addr][DATA_W-1], mem[wr_addr]} + {wr_data[DATA_W-1], wr_data};
        clip    = (sum[DATA_W] != sum[DATA_W-1]);
        acc_val = sum[DATA_W-1:0];
        if (clip) acc_val = sum[DATA_W] ? MIN_VAL : MAX_VAL;
    end

`ifdef WEIGHT_BANK_RAND_INIT_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Not reloaded on init_start so every re-init produces a fresh pattern.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) lfsr <= LFSR_SEED;
        else if (busy) lfsr <= {lfsr[14:0], lfsr_fb};
    end

    assign init_val = $signed(lfsr[DATA_W-1:0]) >>> 3;
`else
    assign init_val = '0;
`endif

    always_ff @(posedge Clock) begin
        if (busy) mem[ptr] <= init_val;
        else if (wr_act) mem[wr_addr] <= wr_mode ? acc_val : wr_data;
    end

    // Read samples mem before this edge's write lands, giving read-before-write.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            rd_valid <= rd_act;
            if (rd_act) rd_data <= rd_ok ? mem[rd_addr] : '0;
            addr_err <= run & ((rd_en & ~rd_ok) | (wr_en & ~wr_ok));
            sat_flag <= wr_act & wr_mode & clip;
        end
    end
endmodule

// File: doc/weight_bank.md
Name: weight_bank

Overview:
- Parametrised weight store for the drowsiness-detector network layers.
- Holds DEPTH signed weights of DATA_W bits.
- Provides a registered read port and a write port with two modes:
  - overwrite (initial load);
  - saturating accumulate (training update, weight += delta).
- After reset or on request, a sequencer sweeps the whole array, so contents are never undefined when the first layer reads.

Parameters:
DATA_W, 10, signed weight width (two's complement)
DEPTH, 65, number of weight entries
ADDR_W, 7, address width; must satisfy 2**ADDR_W >= DEPTH
LFSR_SEED, 16'hACE1, non-zero seed for the optional random-init generator

Ports:
Clock  input  1  rising-edge clock
Rst  input  1  asynchronous active-low reset
init_start  input  1  one-cycle pulse; restarts the init sweep
busy  output  1  high while the sweep runs; access ports ignored
wr_en  input  1  write request
wr_mode  input  1  0 = overwrite, 1 = saturating accumulate
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  signed data or delta
rd_en  input  1  read request
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  signed read data, registered
rd_valid  output  1  one-cycle pulse, aligned with rd_data
addr_err  output  1  one-cycle pulse: an accepted request had address >= DEPTH
sat_flag  output  1  one-cycle pulse: accumulate result was clipped

Behaviour:
- Reset (Rst=0, asynchronous):
  - FSM enters INIT; sweep pointer = 0.
  - busy=1, rd_data=0, rd_valid=0, addr_err=0, sat_flag=0.
  - Array contents are not reset asynchronously; they are cleared by the sweep.
- FSM states and transitions:
  - INIT: writes the init value to entry ptr, then ptr+1, one entry per cycle. After ptr = DEPTH-1 is written, goes to RUN. busy=1 throughout. The sweep lasts exactly DEPTH cycles after Rst deasserts.
  - RUN: busy=0; access ports active. init_start=1 returns to INIT with ptr=0 on the next edge. Any wr_en/rd_en in that same cycle is still serviced.
  - While in INIT: wr_en, rd_en and init_start are ignored; rd_valid, addr_err and sat_flag stay 0.
- Read:
  - rd_en=1 in RUN latches mem[rd_addr] into rd_data at the next edge; rd_valid=1 for that one cycle. Latency is 1.
  - rd_data holds its value until the next valid read.
- Overwrite write (wr_mode=0): mem[wr_addr] <= wr_data at the edge.
- Accumulate write (wr_mode=1):
  - sum = mem[wr_addr] + wr_data, computed at DATA_W+1 bits, sign-extended.
  - Result is clipped to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
  - On clip: sat_flag=1 for one cycle; the clipped value is stored.
- Simultaneous read and write to the same address: read-before-write. rd_data returns the pre-write value; the new value is visible on the following read.
- Back-to-back accumulates to the same address in consecutive cycles must each see the previous result. There is no hazard window because the update is single-cycle.
- Out of range (addr >= DEPTH, addresses 65..127 by default):
  - Write is dropped.
  - Read returns rd_data=0 with rd_valid=1.
  - addr_err=1 for one cycle either way. If read and write both fault in the same cycle, a single pulse is produced.
- Reset asserted mid-sweep or mid-access: immediate return to the reset state; the sweep restarts from 0 after release.

Optional Feature:
- Macro: WEIGHT_BANK_RAND_INIT_EN.
- Defined:
  - The INIT sweep writes pseudo-random weights from a 16-bit Fibonacci LFSR, taps 16,14,13,11, loaded with LFSR_SEED on reset.
  - The LFSR steps once per INIT cycle.
  - The low DATA_W bits are taken and arithmetic-shifted right by 3 to keep initial weights small.
  - The LFSR is not reseeded on init_start, so each re-init yields a new set.
- Undefined: the sweep writes 0 to every entry, and no LFSR logic is instantiated.

Test Plan:
- Reset release with no stimulus -> busy=1 for exactly 65 cycles, then 0. Reading addresses 0..64 returns 0 (macro off) with rd_valid one cycle after each rd_en.
- Overwrite addr 5 = -3 (10'h3FD), then read addr 5 -> rd_data=-3 at latency 1, rd_valid single pulse.
- Accumulate:
  - addr 7 preloaded with 500, accumulate +20 -> stored 511, sat_flag pulse.
  - Preload -510, accumulate -5 -> stored -512, sat_flag pulse.
  - Preload 100, accumulate -30 -> stored 70, no sat_flag.
- Same-cycle read and write, addr 3 old=12, new=40 -> rd_data=12. The next read returns 40.
- Write to addr 70 and read addr 100 -> write dropped, rd_data=0, rd_valid=1, addr_err pulses. Entries 0..64 are unchanged.
- init_start pulse in RUN with prior data loaded -> busy high for 65 cycles, all entries re-initialised.
  - Macro on: the two successive sweeps produce different, non-zero patterns.
  - Rst pulsed mid-sweep: busy stays high, and the sweep restarts and lasts the full 65 cycles.
